// File: rtl/sum_accum.sv
// sum_accum: four-lane saturating read-modify-write accumulator with full-memory clear.
// Ports: clk/rst (async active-high); clr_start/acc_start start a pass from IDLE;
// in_valid/in_ready/in_last/in_mask/idx1..4/val1..4 carry input beats;
// we/addr1..4/wd1..4 drive the four memory write ports, sumr1..4 are its
// combinational read data; busy/done/beat_cnt report pass status.
module sum_accum #(
  parameter int DEPTH = 1024,
  parameter int AW = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_start,
  input  logic             acc_start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [3:0]       in_mask,
  input  logic [AW-1:0]    idx1,
  input  logic [AW-1:0]    idx2,
  input  logic [AW-1:0]    idx3,
  input  logic [AW-1:0]    idx4,
  input  logic [31:0]      val1,
  input  logic [31:0]      val2,
  input  logic [31:0]      val3,
  input  logic [31:0]      val4,
  output logic             we,
  output logic [31:0]      addr1,
  output logic [31:0]      addr2,
  output logic [31:0]      addr3,
  output logic [31:0]      addr4,
  output logic [31:0]      wd1,
  output logic [31:0]      wd2,
  output logic [31:0]      wd3,
  output logic [31:0]      wd4,
  input  logic [31:0]      sumr1,
  input  logic [31:0]      sumr2,
  input  logic [31:0]      sumr3,
  input  logic [31:0]      sumr4,
  output logic             busy,
  output logic             done,
  output logic [15:0]      beat_cnt
);
  localparam int KW = $clog2(DEPTH / 4);
  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, FLUSH} state_t;
  state_t state, state_nx;
  logic [KW-1:0] k;
  logic s_valid;
  logic [3:0] s_mask;
  logic [3:0][AW-1:0] s_idx;
  logic [3:0][31:0] s_val, sumr, addr, wd;
  logic [3:0][34:0] sum;
  logic accept, clearing, clr_end;
  assign sumr = {sumr4, sumr3, sumr2, sumr1};
  assign {addr4, addr3, addr2, addr1} = addr;
  assign {wd4, wd3, wd2, wd1} = wd;
  assign in_ready = state == ACCUM;
  assign accept = in_ready && in_valid;
  assign clearing = state == CLEAR;
  assign clr_end = clearing && k == KW'(DEPTH / 4 - 1);
  assign busy = state != IDLE;
  assign we = clearing || s_valid;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = clr_start ? CLEAR : acc_start ? ACCUM : IDLE;
      CLEAR:   state_nx = clr_end ? IDLE : CLEAR;
      ACCUM:   state_nx = accept && in_last ? FLUSH : ACCUM;
      default: state_nx = IDLE;
    endcase
  end
  // Every lane sums all enabled lanes sharing its bin, so colliding write
  // ports always carry identical data; 35 bits hold sumr plus four increments.
  always_comb begin
    sum = '0;
    addr = '0;
    wd = '0;
    for (int i = 0; i < 4; i++) begin
      sum[i] = {3'b0, sumr[i]};
      for (int j = 0; j < 4; j++)
        sum[i] = sum[i] + (s_mask[j] && s_idx[j] == s_idx[i] ? {3'b0, s_val[j]} : 35'd0);
      addr[i] = clearing ? 32'({k, 2'(i)}) : s_valid ? 32'(s_idx[i]) : 32'd0;
      wd[i] = !s_valid ? 32'd0 : |sum[i][34:32] ? 32'hFFFF_FFFF : sum[i][31:0];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      k <= '0;
      s_valid <= 1'b0;
      s_mask <= '0;
      s_idx <= '0;
      s_val <= '0;
      done <= 1'b0;
      beat_cnt <= '0;
    end else begin
      state <= state_nx;
      k <= clearing ? k + KW'(1) : '0;
      s_valid <= accept;
      done <= clr_end || state == FLUSH;
      if (accept) begin
        s_mask <= in_mask;
        s_idx <= {idx4, idx3, idx2, idx1};
        s_val <= {val4, val3, val2, val1};
      end
      beat_cnt <= state == IDLE && !clr_start && acc_start ? 16'd0 :
                  accept ? beat_cnt + 16'd1 : beat_cnt;
    end
  end
endmodule

// File: tb/tb_sum_accum.sv
// tb_sum_accum: self-checking bench for sum_accum with a behavioural memory and reference bins.
module tb_sum_accum;
  logic clk = 1'b0, rst = 1'b1;
  logic clr_start = 1'b0, acc_start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [3:0] in_mask = '0;
  logic [9:0] idx1 = '0, idx2 = '0, idx3 = '0, idx4 = '0;
  logic [31:0] val1 = '0, val2 = '0, val3 = '0, val4 = '0;
  logic in_ready, we, busy, done;
  logic [15:0] beat_cnt;
  logic [31:0] addr1, addr2, addr3, addr4, wd1, wd2, wd3, wd4, sumr1, sumr2, sumr3, sumr4;
  logic [3:0][31:0] addr_a, wd_a;
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  logic poke_en = 1'b0;
  logic [9:0] poke_addr = '0;
  logic [31:0] poke_data = '0;
  int total = 0, bad = 0;

  typedef struct {
    logic [3:0] m;
    logic [3:0][9:0] ix;
    logic [3:0][31:0] vl;
    logic [3:0][31:0] ew;
  } vec_t;
  vec_t tbl [3];

  sum_accum dut (
    .clk(clk), .rst(rst), .clr_start(clr_start), .acc_start(acc_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_mask(in_mask),
    .idx1(idx1), .idx2(idx2), .idx3(idx3), .idx4(idx4),
    .val1(val1), .val2(val2), .val3(val3), .val4(val4),
    .we(we), .addr1(addr1), .addr2(addr2), .addr3(addr3), .addr4(addr4),
    .wd1(wd1), .wd2(wd2), .wd3(wd3), .wd4(wd4),
    .sumr1(sumr1), .sumr2(sumr2), .sumr3(sumr3), .sumr4(sumr4),
    .busy(busy), .done(done), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;
  assign addr_a = {addr4, addr3, addr2, addr1};
  assign wd_a = {wd4, wd3, wd2, wd1};
  assign sumr1 = mem[addr1[9:0]];
  assign sumr2 = mem[addr2[9:0]];
  assign sumr3 = mem[addr3[9:0]];
  assign sumr4 = mem[addr4[9:0]];
  always @(posedge clk) begin
    if (we) begin
      mem[addr1[9:0]] <= wd1;
      mem[addr2[9:0]] <= wd2;
      mem[addr3[9:0]] <= wd3;
      mem[addr4[9:0]] <= wd4;
    end
    if (poke_en) mem[poke_addr] <= poke_data;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    poke_en = 1'b1;
    poke_addr = a;
    poke_data = d;
    ref_mem[a] = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic do_clear();
    int errs = 0, nz = 0;
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    for (int c = 0; c < 256; c++) begin
      if (we !== 1'b1 || busy !== 1'b1 || done !== 1'b0) errs++;
      for (int i = 0; i < 4; i++)
        if (addr_a[i] !== 32'(4 * c + i) || wd_a[i] !== 32'd0) errs++;
      @(negedge clk);
    end
    chk("clear_seq_errs", errs, 0);
    chk("clear_done", done, 1);
    chk("clear_busy", busy, 0);
    chk("clear_we_off", we, 0);
    @(negedge clk);
    chk("clear_done_once", done, 0);
    for (int a = 0; a < 1024; a++) begin
      if (mem[a] !== 32'd0) nz++;
      ref_mem[a] = 32'd0;
    end
    chk("clear_mem_nonzero", nz, 0);
  endtask

  task automatic start_acc();
    acc_start = 1'b1;
    @(negedge clk);
    acc_start = 1'b0;
    chk("acc_busy", busy, 1);
    chk("acc_ready", in_ready, 1);
    chk("acc_cnt0", beat_cnt, 0);
  endtask

  // Reference: lanes applied one after another with saturation; each lane's
  // write data must then equal the final bin it addresses.
  task automatic beat(input logic [3:0] m, input logic [3:0][9:0] ix,
                      input logic [3:0][31:0] vl, input logic lst,
                      output logic [3:0][31:0] obs);
    logic [32:0] t;
    chk("beat_ready", in_ready, 1);
    in_valid = 1'b1;
    in_last = lst;
    in_mask = m;
    {idx4, idx3, idx2, idx1} = ix;
    {val4, val3, val2, val1} = vl;
    for (int j = 0; j < 4; j++)
      if (m[j]) begin
        t = {1'b0, ref_mem[ix[j]]} + {1'b0, vl[j]};
        ref_mem[ix[j]] = t[32] ? 32'hFFFF_FFFF : t[31:0];
      end
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    chk("beat_we", we, 1);
    for (int i = 0; i < 4; i++) begin
      chk("beat_addr", addr_a[i], 32'(ix[i]));
      chk("beat_wd", wd_a[i], ref_mem[ix[i]]);
    end
    obs = wd_a;
  endtask

  task automatic end_pass(input int n);
    chk("flush_busy", busy, 1);
    chk("flush_ready", in_ready, 0);
    @(negedge clk);
    chk("pass_done", done, 1);
    chk("pass_busy", busy, 0);
    chk("pass_we_off", we, 0);
    chk("pass_cnt", beat_cnt, 32'(n));
    @(negedge clk);
    chk("pass_done_once", done, 0);
    chk("pass_cnt_hold", beat_cnt, 32'(n));
  endtask

  initial begin
    logic [3:0][31:0] obs;
    logic [3:0][9:0] rix;
    logic [3:0][31:0] rvl;
    tbl[0] = '{4'hF, {10'd4, 10'd3, 10'd2, 10'd1}, {32'd40, 32'd30, 32'd20, 32'd10},
               {32'd40, 32'd30, 32'd20, 32'd10}};
    tbl[1] = '{4'hF, {10'd9, 10'd5, 10'd5, 10'd5}, {32'd4, 32'd3, 32'd2, 32'd1},
               {32'd4, 32'd6, 32'd6, 32'd6}};
    tbl[2] = '{4'b0101, {10'd8, 10'd8, 10'd7, 10'd7}, {4{32'd5}}, {4{32'd5}}};
    repeat (3) @(negedge clk);
    chk("rst_we", we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cnt", beat_cnt, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_addr1", addr1, 0);
    chk("rst_wd1", wd1, 0);
    rst = 1'b0;
    @(negedge clk);
    poke(10'd3, 32'hDEAD_BEEF);
    poke(10'd512, 32'd7);
    poke(10'd1023, 32'd1);
    do_clear();
    for (int t = 0; t < 3; t++) begin
      start_acc();
      beat(tbl[t].m, tbl[t].ix, tbl[t].vl, 1'b1, obs);
      for (int i = 0; i < 4; i++) chk("tbl_wd", obs[i], tbl[t].ew[i]);
      end_pass(1);
      for (int i = 0; i < 4; i++) chk("tbl_bin", mem[tbl[t].ix[i]], tbl[t].ew[i]);
    end
    poke(10'd0, 32'hFFFF_FFF0);
    start_acc();
    for (int b = 0; b < 3; b++) beat(4'hF, {4{10'd0}}, {4{32'd4}}, b == 2, obs);
    chk("sat_wd", obs[0], 32'hFFFF_FFFF);
    end_pass(3);
    chk("sat_bin", mem[0], 32'hFFFF_FFFF);
    start_acc();
    beat(4'b0001, {4{10'd30}}, {32'd0, 32'd0, 32'd0, 32'd1}, 1'b0, obs);
    chk("raw_first", obs[0], 1);
    beat(4'b0001, {4{10'd30}}, {32'd0, 32'd0, 32'd0, 32'd1}, 1'b1, obs);
    chk("raw_second", obs[3], 2);
    end_pass(2);
    chk("raw_bin", mem[30], 2);
    start_acc();
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        chk("gap_we", we, 0);
      end
      for (int i = 0; i < 4; i++) begin
        rix[i] = 10'($urandom_range(0, 15));
        rvl[i] = $urandom_range(0, 5) == 0 ? 32'hF000_0000 + $urandom_range(0, 255) : $urandom_range(0, 1000);
      end
      beat(4'($urandom_range(0, 15)), rix, rvl, n == 39, obs);
    end
    end_pass(40);
    for (int a = 0; a < 16; a++) chk("rand_bin", mem[a], ref_mem[a]);
    clr_start = 1'b1;
    @(negedge clk);
    clr_start = 1'b0;
    repeat (99) @(negedge clk);
    chk("midclr_we", we, 1);
    chk("midclr_addr", addr1, 396);
    rst = 1'b1;
    #1;
    chk("midrst_we", we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_addr", addr1, 0);
    chk("midrst_wd", wd1, 0);
    chk("midrst_ready", in_ready, 0);
    chk("midrst_cnt", beat_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start_acc();
    beat(4'hF, {10'd603, 10'd602, 10'd601, 10'd600}, {32'd4, 32'd3, 32'd2, 32'd1}, 1'b1, obs);
    chk("post_wd1", obs[0], 1);
    end_pass(1);
    chk("post_bin603", mem[603], 4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
